// File: rtl/apb_rb_pkg.sv
// Shared definitions for the APB-to-register-bus bridge.
//   state_t     : bridge FSM encoding (IDLE, WAIT, RESP)
//   align_lsbs  : number of byte-offset address bits for a given data width
//   wd_cnt_w    : watchdog counter width for a given TIMEOUT (at least 1 bit)
package apb_rb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // 8-bit data has no byte offset bits, 16-bit has one, 32-bit has two.
    function automatic int align_lsbs(input int data_w);
        if (data_w >= 32)
            return 2;
        else if (data_w >= 16)
            return 1;
        else
            return 0;
    endfunction

    // A disabled watchdog (TIMEOUT=0) still gets a 1-bit counter so the
    // declaration stays legal.
    function automatic int wd_cnt_w(input int timeout);
        if (timeout < 1)
            return 1;
        else
            return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_rb_bridge_gen_if.sv
// Bus bundle between an APB master / register block pair and the bridge.
// Handshake: an APB transfer is a setup cycle (psel=1, penable=0) followed
// by access cycles (psel=1, penable=1) that end in the cycle pready=1.
// On the register side rstrobe/wstrobe is a one-cycle request; the block
// answers with rack/wack (addrerr valid alongside) in that cycle or later.
//   slave  modport : bridge view (APB slave, register-bus requester)
//   master modport : environment view (APB master plus register block)
interface apb_rb_bridge_gen_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    import apb_rb_pkg::*;

    logic [ADDR_W-1:0]   apb_paddr;
    logic                apb_psel;
    logic                apb_penable;
    logic                apb_pwrite;
    logic [DATA_W-1:0]   apb_pwdata;
    logic [DATA_W/8-1:0] apb_pstrb;
    logic                apb_pready;
    logic [DATA_W-1:0]   apb_prdata;
    logic                apb_pslverr;

    logic                apb_rstrobe;
    logic [ADDR_W-1:0]   apb_raddr;
    logic [DATA_W-1:0]   apb_rdata;
    logic                apb_rack;
    logic                apb_raddrerr;
    logic                apb_wstrobe;
    logic [ADDR_W-1:0]   apb_waddr;
    logic [DATA_W-1:0]   apb_wdata;
    logic [DATA_W/8-1:0] apb_wstrb;
    logic                apb_wack;
    logic                apb_waddrerr;

    modport slave (
        input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        input  apb_rdata, apb_rack, apb_raddrerr, apb_wack, apb_waddrerr,
        output apb_pready, apb_prdata, apb_pslverr,
        output apb_rstrobe, apb_raddr, apb_wstrobe, apb_waddr, apb_wdata, apb_wstrb
    );

    modport master (
        output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        output apb_rdata, apb_rack, apb_raddrerr, apb_wack, apb_waddrerr,
        input  apb_pready, apb_prdata, apb_pslverr,
        input  apb_rstrobe, apb_raddr, apb_wstrobe, apb_waddr, apb_wdata, apb_wstrb
    );

endinterface

// File: rtl/apb_rb_watchdog.sv
// Ack-timeout counter for the bridge WAIT state.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (on WAIT entry)
//   enable     : a WAIT cycle without ack
//   expire     : this enabled cycle is the last one allowed (TIMEOUT-th)
// TIMEOUT = 0 disables expiry entirely.
module apb_rb_watchdog
    import apb_rb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = wd_cnt_w(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expire = (TIMEOUT != 0) && enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_rb_bridge_gen.sv
// APB4 slave to generic register-bus strobe/ack bridge.
//   apb_pclk, apb_presetn : clock, asynchronous active-low reset
//   bus                   : APB and register-bus signals (slave modport)
//   timeout_err           : one-cycle pulse when the ack watchdog fires
//   dbg_state             : current FSM state, for observation only
// A transfer takes setup, one strobe cycle (WAIT) plus any extra wait for
// ack, then one RESP cycle with pready. Misaligned addresses skip WAIT.
module apb_rb_bridge_gen
    import apb_rb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                 apb_pclk,
    input  logic                 apb_presetn,
    apb_rb_bridge_gen_if.slave   bus,
    output logic                 timeout_err,
    output state_t               dbg_state
);
    localparam int              LSB        = align_lsbs(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

    state_t state;
    logic   wr_q;
    logic   setup;
    logic   misaligned;
    logic   ack;
    logic   addrerr;
    logic   wd_clear;
    logic   wd_enable;
    logic   wd_expire;

    assign setup      = bus.apb_psel && !bus.apb_penable;
    assign misaligned = (ALIGN_CHECK != 0) && ((bus.apb_paddr & ALIGN_MASK) != '0);
    // Only the ack matching the latched direction counts.
    assign ack        = wr_q ? bus.apb_wack     : bus.apb_rack;
    assign addrerr    = wr_q ? bus.apb_waddrerr : bus.apb_raddrerr;
    assign wd_clear   = (state == IDLE) && setup && !misaligned;
    assign wd_enable  = (state == WAIT) && bus.apb_psel && !ack;
    assign dbg_state  = state;

    apb_rb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (apb_pclk),
        .rst_n  (apb_presetn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            bus.apb_pready  <= 1'b0;
            bus.apb_pslverr <= 1'b0;
            bus.apb_prdata  <= '0;
            bus.apb_rstrobe <= 1'b0;
            bus.apb_raddr   <= '0;
            bus.apb_wstrobe <= 1'b0;
            bus.apb_waddr   <= '0;
            bus.apb_wdata   <= '0;
            bus.apb_wstrb   <= '0;
            timeout_err     <= 1'b0;
        end else begin
            // Strobes and the timeout flag are single-cycle pulses.
            bus.apb_rstrobe <= 1'b0;
            bus.apb_wstrobe <= 1'b0;
            timeout_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup) begin
                        wr_q <= bus.apb_pwrite;
                        if (bus.apb_pwrite) begin
                            bus.apb_waddr <= bus.apb_paddr;
                            bus.apb_wdata <= bus.apb_pwdata;
                            bus.apb_wstrb <= bus.apb_pstrb;
                        end else begin
                            bus.apb_raddr <= bus.apb_paddr;
                            bus.apb_wstrb <= '0;
                        end
                        if (misaligned) begin
                            bus.apb_pready  <= 1'b1;
                            bus.apb_pslverr <= 1'b1;
                            bus.apb_prdata  <= '0;
                            state           <= RESP;
                        end else begin
                            bus.apb_rstrobe <= !bus.apb_pwrite;
                            bus.apb_wstrobe <= bus.apb_pwrite;
                            state           <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.apb_psel) begin
                        // Master abandoned the transfer: no response.
                        state <= IDLE;
                    end else if (ack) begin
                        bus.apb_pready  <= 1'b1;
                        bus.apb_pslverr <= addrerr;
                        bus.apb_prdata  <= (!wr_q && !addrerr) ? bus.apb_rdata : '0;
                        state           <= RESP;
                    end else if (wd_expire) begin
                        bus.apb_pready  <= 1'b1;
                        bus.apb_pslverr <= 1'b1;
                        bus.apb_prdata  <= '0;
                        timeout_err     <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    bus.apb_pready  <= 1'b0;
                    bus.apb_pslverr <= 1'b0;
                    bus.apb_prdata  <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rb_bridge_gen.sv
module tb_apb_rb_bridge_gen;
    import apb_rb_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int SW      = DATA_W / 8;
    localparam int TIMEOUT = 4;
    localparam int EW      = 8 + 1 + 1 + DATA_W;
    localparam int NO_ACK  = 255;
    localparam int BUDGET  = 20;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   timeout_err;
    state_t dbg_state;

    apb_rb_bridge_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_rb_bridge_gen #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT     (TIMEOUT),
        .ALIGN_CHECK (1)
    ) dut (
        .apb_pclk    (clk),
        .apb_presetn (rst_n),
        .bus         (bus),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang required finish");
        $fatal(1, "global timeout");
    end

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     strb;
        int                dly;      // cycles from strobe to ack, NO_ACK = never
        logic              aerr;
        logic [DATA_W-1:0] rdata;
        int                exp_lat;  // pready cycle index, setup is cycle 0
        logic              exp_err;
        logic [DATA_W-1:0] exp_data;
        logic              exp_to;
        int                exp_strobes;
    } vec_t;

    vec_t vecs[12];
    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [SW-1:0] strb,
                                input int dly, input logic aerr, input logic [DATA_W-1:0] rdata,
                                input int lat, input logic err, input logic [DATA_W-1:0] data,
                                input logic to, input int strobes);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.dly = dly;
        v.aerr = aerr; v.rdata = rdata; v.exp_lat = lat; v.exp_err = err;
        v.exp_data = data; v.exp_to = to; v.exp_strobes = strobes;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.apb_psel     = 1'b0;
        bus.apb_penable  = 1'b0;
        bus.apb_pwrite   = 1'b0;
        bus.apb_paddr    = '0;
        bus.apb_pwdata   = '0;
        bus.apb_pstrb    = '0;
        bus.apb_rack     = 1'b0;
        bus.apb_wack     = 1'b0;
        bus.apb_raddrerr = 1'b0;
        bus.apb_waddrerr = 1'b0;
        bus.apb_rdata    = '0;
    endtask

    task automatic run_vec(input int i);
        vec_t          v;
        logic [EW-1:0] e;
        int            n;
        int            ack_at;
        int            strobes;
        bit            done;
        logic [DATA_W-1:0] got_data;
        logic          got_err;
        logic          got_to;
        v = vecs[i];
        exp_q.push_back({8'(v.exp_lat), v.exp_to, v.exp_err, v.exp_data});
        // setup phase
        bus.apb_psel    = 1'b1;
        bus.apb_penable = 1'b0;
        bus.apb_paddr   = v.addr;
        bus.apb_pwrite  = v.wr;
        bus.apb_pwdata  = v.wdata;
        bus.apb_pstrb   = v.strb;
        tick();
        bus.apb_penable = 1'b1;
        n = 1; ack_at = -1; strobes = 0; done = 0;
        got_data = '0; got_err = 1'b0; got_to = 1'b0;
        while (!done && n <= BUDGET) begin
            bus.apb_rack = 1'b0; bus.apb_wack = 1'b0;
            bus.apb_raddrerr = 1'b0; bus.apb_waddrerr = 1'b0; bus.apb_rdata = '0;
            if (bus.apb_rstrobe || bus.apb_wstrobe) begin
                strobes++;
                ack_at = (v.dly == NO_ACK) ? -1 : n + v.dly;
                if (v.wr) begin
                    check($sformatf("v%0d wstrobe", i), bus.apb_wstrobe, 1);
                    check($sformatf("v%0d waddr", i), bus.apb_waddr, v.addr);
                    check($sformatf("v%0d wdata", i), bus.apb_wdata, v.wdata);
                    check($sformatf("v%0d wstrb", i), bus.apb_wstrb, v.strb);
                end else begin
                    check($sformatf("v%0d rstrobe", i), bus.apb_rstrobe, 1);
                    check($sformatf("v%0d raddr", i), bus.apb_raddr, v.addr);
                    check($sformatf("v%0d wstrb_rd", i), bus.apb_wstrb, 0);
                end
            end
            if (bus.apb_pready) begin
                done     = 1;
                got_data = bus.apb_prdata;
                got_err  = bus.apb_pslverr;
                got_to   = timeout_err;
            end else begin
                if (n == ack_at) begin
                    if (v.wr) begin
                        bus.apb_wack = 1'b1; bus.apb_waddrerr = v.aerr;
                    end else begin
                        bus.apb_rack = 1'b1; bus.apb_raddrerr = v.aerr; bus.apb_rdata = v.rdata;
                    end
                end
                tick();
                n++;
            end
        end
        e = exp_q.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d pready_wait: got no pready in %0d cycles expected pready at %0d",
                     i, BUDGET, v.exp_lat);
        end else begin
            check($sformatf("v%0d latency", i), n, e[EW-1 -: 8]);
            check($sformatf("v%0d timeout_err", i), got_to, e[DATA_W+1]);
            check($sformatf("v%0d pslverr", i), got_err, e[DATA_W]);
            check($sformatf("v%0d prdata", i), got_data, e[DATA_W-1:0]);
        end
        check($sformatf("v%0d strobe_count", i), strobes, v.exp_strobes);
        idle_bus();
        tick();
        check($sformatf("v%0d pready_drop", i), bus.apb_pready, 0);
        check($sformatf("v%0d timeout_drop", i), timeout_err, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        //           wr   addr     wdata         strb  dly     aerr rdata         lat err data          to  strobes
        vecs[0]  = mk(1, 12'h00C, 32'hA5A5_0001, 4'hF, 0,      0, 32'h0,         2, 0, 32'h0,          0, 1);
        vecs[1]  = mk(0, 12'h010, 32'h0,         4'hF, 3,      0, 32'h0000_00C3, 5, 0, 32'h0000_00C3,  0, 1);
        vecs[2]  = mk(0, 12'h7FC, 32'h0,         4'h0, 0,      1, 32'hDEAD_BEEF, 2, 1, 32'h0,          0, 1);
        vecs[3]  = mk(1, 12'h00D, 32'h1111_2222, 4'hF, 0,      0, 32'h0,         1, 1, 32'h0,          0, 0);
        vecs[4]  = mk(0, 12'h020, 32'h0,         4'h0, NO_ACK, 0, 32'h0,         5, 1, 32'h0,          1, 1);
        vecs[5]  = mk(0, 12'h000, 32'h0,         4'h0, 0,      0, 32'h1234_5678, 2, 0, 32'h1234_5678,  0, 1);
        vecs[6]  = mk(1, 12'h008, 32'h0F0F_0F0F, 4'h0, 1,      0, 32'h0,         3, 0, 32'h0,          0, 1);
        vecs[7]  = mk(0, 12'h018, 32'h0,         4'h0, 3,      0, 32'h0000_55AA, 5, 0, 32'h0000_55AA,  0, 1);
        vecs[8]  = mk(1, 12'h030, 32'hCAFE_0000, 4'h5, 2,      1, 32'h0,         4, 1, 32'h0,          0, 1);
        vecs[9]  = mk(0, 12'h002, 32'h0,         4'h0, 0,      0, 32'hFFFF_FFFF, 1, 1, 32'h0,          0, 0);
        vecs[10] = mk(1, 12'h004, 32'h8765_4321, 4'h3, 0,      0, 32'h0,         2, 0, 32'h0,          0, 1);
        vecs[11] = mk(0, 12'h004, 32'h0,         4'h0, 0,      0, 32'h0BAD_F00D, 2, 0, 32'h0BAD_F00D,  0, 1);

        idle_bus();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst pready", bus.apb_pready, 0);
        check("rst pslverr", bus.apb_pslverr, 0);
        check("rst prdata", bus.apb_prdata, 0);
        check("rst rstrobe", bus.apb_rstrobe, 0);
        check("rst wstrobe", bus.apb_wstrobe, 0);
        check("rst raddr", bus.apb_raddr, 0);
        check("rst waddr", bus.apb_waddr, 0);
        check("rst wdata", bus.apb_wdata, 0);
        check("rst wstrb", bus.apb_wstrb, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i <= 4; i++) run_vec(i);

        // Late rack after the watchdog fired must be ignored.
        bus.apb_rack = 1'b1; bus.apb_rdata = 32'hFFFF_FFFF;
        tick();
        check("late_ack pready", bus.apb_pready, 0);
        check("late_ack rstrobe", bus.apb_rstrobe, 0);
        check("late_ack state", dbg_state, IDLE);
        idle_bus();
        tick();

        for (int i = 5; i <= 9; i++) run_vec(i);

        // psel dropped during WAIT: back to IDLE, no response, ack ignored.
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.apb_paddr = 12'h040; bus.apb_pwrite = 1'b0;
        tick();
        check("abort rstrobe", bus.apb_rstrobe, 1);
        bus.apb_psel = 1'b0; bus.apb_penable = 1'b0;
        tick();
        check("abort state", dbg_state, IDLE);
        check("abort pready", bus.apb_pready, 0);
        bus.apb_rack = 1'b1; bus.apb_rdata = 32'h1357_9BDF;
        tick();
        check("abort late_pready", bus.apb_pready, 0);
        check("abort no_restrobe", bus.apb_rstrobe, 0);
        idle_bus();
        tick();

        // penable without a setup phase is ignored.
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b1; bus.apb_paddr = 12'h044; bus.apb_pwrite = 1'b1;
        bus.apb_pstrb = 4'hF;
        tick();
        check("noset wstrobe", bus.apb_wstrobe, 0);
        tick();
        check("noset state", dbg_state, IDLE);
        check("noset pready", bus.apb_pready, 0);
        idle_bus();
        tick();

        // Reset in the middle of WAIT clears outputs at once.
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.apb_paddr = 12'h050; bus.apb_pwrite = 1'b1;
        bus.apb_pwdata = 32'h2468_ACE0; bus.apb_pstrb = 4'hF;
        tick();
        bus.apb_penable = 1'b1;
        check("mid_rst wstrobe_before", bus.apb_wstrobe, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst wstrobe", bus.apb_wstrobe, 0);
        check("mid_rst waddr", bus.apb_waddr, 0);
        check("mid_rst wdata", bus.apb_wdata, 0);
        check("mid_rst wstrb", bus.apb_wstrb, 0);
        check("mid_rst state", dbg_state, IDLE);
        idle_bus();
        bus.apb_wack = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst pready", bus.apb_pready, 0);
        check("post_rst wstrobe", bus.apb_wstrobe, 0);
        idle_bus();
        tick();

        run_vec(10);
        run_vec(11);

        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
